// File: rtl/mem_arbiter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_ctrl_if
// Purpose  : Bundles the cache-side request/response signals and the
//            single-ported RAM signals handled by mem_arbiter_ctrl.
// Modports : slave  - the arbiter: takes cache requests and RAM responses,
//                     drives the waits, load data and RAM commands.
//            master - the environment (caches plus RAM model).
// Signals  : iREN/iaddr               instruction read request
//            dREN/dWEN/daddr/dstore   data read/write request
//            iwait/dwait/iload/dload  responses to the caches
//            ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate  RAM port
//            ram_err                  sticky RAM error flag
// Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_ctrl_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        iwait;
   logic        dwait;
   logic [31:0] iload;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        ram_err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_ctrl
// Purpose  : Arbitrates the instruction and data cache ports onto one
//            single-ported RAM. Data wins ties; after STARVE_LIMIT data
//            completions with an instruction request pending, the next
//            grant goes to the instruction port.
// Ports    : CLK   clock
//            nRST  synchronous active-low reset
//            bus   mem_arbiter_ctrl_if.slave (cache and RAM signals)
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter_ctrl #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic                 CLK,
   input  logic                 nRST,
   mem_arbiter_ctrl_if.slave    bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DSERV = 2'd1;
   localparam logic [1:0] ISERV = 2'd2;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             err_q, err_d;

   logic             d_req;
   logic             ram_access;
   logic             ram_error;
   logic             i_starved;
   logic [CNT_W-1:0] starve_inc;

   logic             ram_ren;
   logic             ram_wen;
   logic [31:0]      ram_addr;
   logic [31:0]      ram_store;
   logic             iwait;
   logic             dwait;

   assign d_req      = bus.dREN | bus.dWEN;
   assign ram_access = (bus.ramstate == RAM_ACCESS);
   assign ram_error  = (bus.ramstate == RAM_ERROR);
   // Instruction port has waited long enough: it beats a pending data request.
   assign i_starved  = bus.iREN & (starve_q >= LIMIT);
   // Saturating increment so the counter never wraps back to zero.
   assign starve_inc = (starve_q >= LIMIT) ? LIMIT : (starve_q + CNT_W'(1));

   always_comb begin
      state_d   = state_q;
      starve_d  = starve_q;
      err_d     = err_q;
      ram_ren   = 1'b0;
      ram_wen   = 1'b0;
      ram_addr  = 32'd0;
      ram_store = 32'd0;
      iwait     = 1'b1;
      dwait     = 1'b1;

      case (state_q)
         IDLE: begin
            if (d_req && !i_starved) begin
               state_d = DSERV;
            end else if (bus.iREN) begin
               state_d = ISERV;
            end
         end

         DSERV: begin
            ram_addr  = bus.daddr;
            ram_store = bus.dstore;
            ram_wen   = bus.dWEN;
            ram_ren   = bus.dREN & ~bus.dWEN;
            if (!d_req) begin
               // Request withdrawn: leave without completing or counting.
               state_d = IDLE;
            end else if (ram_access) begin
               dwait    = 1'b0;
               state_d  = IDLE;
               starve_d = bus.iREN ? starve_inc : '0;
            end else if (ram_error) begin
               err_d = 1'b1;
            end
         end

         ISERV: begin
            ram_addr = bus.iaddr;
            ram_ren  = 1'b1;
            if (!bus.iREN) begin
               state_d = IDLE;
            end else if (ram_access) begin
               iwait    = 1'b0;
               state_d  = IDLE;
               starve_d = '0;
            end else if (ram_error) begin
               err_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= IDLE;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   assign bus.ramREN   = ram_ren;
   assign bus.ramWEN   = ram_wen;
   assign bus.ramaddr  = ram_addr;
   assign bus.ramstore = ram_store;
   assign bus.iwait    = iwait;
   assign bus.dwait    = dwait;
   assign bus.iload    = bus.ramload;
   assign bus.dload    = bus.ramload;
   assign bus.ram_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter_ctrl
// Purpose  : Self-checking bench for mem_arbiter_ctrl: directed scenarios
//            plus randomized traffic against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter_ctrl;

   localparam int LIMIT = 4;

   logic CLK;
   logic nRST;
   int   errors;
   int   checks;

   mem_arbiter_ctrl_if bus();

   mem_arbiter_ctrl #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Model: who currently owns the RAM (0 none, 1 data, 2 instruction),
   // how many data completions in a row happened while I was waiting,
   // and the sticky error flag.
   int   m_owner  = 0;
   int   m_streak = 0;
   bit   m_err    = 1'b0;

   logic [132:0] exp_v;
   logic [132:0] got_v;

   function automatic logic [132:0] model_out();
      logic iw, dw, rr, rw;
      logic [31:0] ra, rs;
      iw = 1'b1; dw = 1'b1; rr = 1'b0; rw = 1'b0; ra = 32'd0; rs = 32'd0;
      if (m_owner == 1) begin
         ra = bus.daddr;
         rs = bus.dstore;
         rw = bus.dWEN;
         rr = bus.dREN && !bus.dWEN;
         if ((bus.dREN || bus.dWEN) && bus.ramstate == 2'd2) dw = 1'b0;
      end else if (m_owner == 2) begin
         ra = bus.iaddr;
         rr = 1'b1;
         if (bus.iREN && bus.ramstate == 2'd2) iw = 1'b0;
      end
      return {iw, dw, rr, rw, m_err, ra, rs, bus.ramload, bus.ramload};
   endfunction

   function automatic logic [132:0] dut_out();
      return {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ram_err,
              bus.ramaddr, bus.ramstore, bus.iload, bus.dload};
   endfunction

   task automatic model_adv();
      bit dreq;
      dreq = bus.dREN || bus.dWEN;
      if (!nRST) begin
         m_owner = 0; m_streak = 0; m_err = 1'b0;
      end else if (m_owner == 0) begin
         if (dreq && !(bus.iREN && m_streak >= LIMIT)) m_owner = 1;
         else if (bus.iREN) m_owner = 2;
      end else if (m_owner == 1) begin
         if (!dreq) m_owner = 0;
         else if (bus.ramstate == 2'd2) begin
            m_owner  = 0;
            m_streak = bus.iREN ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
         end else if (bus.ramstate == 2'd3) m_err = 1'b1;
      end else begin
         if (!bus.iREN) m_owner = 0;
         else if (bus.ramstate == 2'd2) begin
            m_owner = 0; m_streak = 0;
         end else if (bus.ramstate == 2'd3) m_err = 1'b1;
      end
   endtask

   task automatic sample();
      @(negedge CLK);
      exp_v = model_out();
      got_v = dut_out();
   endtask

   task automatic settle();
      model_adv();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      bus.iREN = 1'b0; bus.iaddr = 32'd0;
      bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'd0; bus.dstore = 32'd0;
      bus.ramstate = 2'd0; bus.ramload = 32'd0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      nRST = 1'b0;
      repeat (2) begin sample(); settle(); end
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      nRST = 1'b0;
      @(posedge CLK); #1;
      for (int c = 0; c < 2; c++) begin
         sample();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_model cyc%0d got=%h exp=%h", c, got_v, exp_v);
         end
         checks++;
         if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ram_err} !== 5'b00110) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=00110",
                     {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ram_err});
         end
         settle();
      end
      nRST = 1'b1;
   endtask

   task automatic test_ifetch_busy();
      int first_low;
      apply_reset();
      first_low = -1;
      bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = 2'd1;
      // cycle 0 is the grant cycle (idle), cycles 1.. are after the grant
      for (int c = 0; c < 6 && first_low < 0; c++) begin
         if (c == 3) begin bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF; end
         sample();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL ifetch_model cyc%0d got=%h exp=%h", c, got_v, exp_v);
         end
         if (bus.iwait === 1'b0) begin
            first_low = c;
            checks++;
            if (bus.iload !== 32'hDEADBEEF || bus.ramaddr !== 32'h40) begin
               errors++;
               $display("FAIL ifetch_data iload=%h addr=%h exp=deadbeef/40", bus.iload, bus.ramaddr);
            end
         end
         settle();
      end
      checks++;
      if (first_low !== 3) begin
         errors++;
         $display("FAIL ifetch_latency got=%0d exp=3", first_low);
      end
      clear_inputs();
   endtask

   task automatic test_priority();
      logic [3:0] seq_got;
      apply_reset();
      seq_got = 4'b0;
      bus.iREN = 1'b1; bus.iaddr = 32'h200;
      bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
      bus.ramstate = 2'd2; bus.ramload = 32'h55AA55AA;
      for (int c = 0; c < 4; c++) begin
         sample();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL priority_model cyc%0d got=%h exp=%h", c, got_v, exp_v);
         end
         if (c == 1) begin
            checks++;
            if ({bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait} !== 4'b1001 ||
                bus.ramaddr !== 32'h80 || bus.ramstore !== 32'h1234) begin
               errors++;
               $display("FAIL priority_dfirst wen/ren/dw/iw=%b addr=%h st=%h",
                        {bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait}, bus.ramaddr, bus.ramstore);
            end
         end
         if (c == 2) begin
            checks++;
            if ({bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait} !== 4'b0011) begin
               errors++;
               $display("FAIL priority_gap got=%b exp=0011",
                        {bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait});
            end
         end
         if (c == 3) begin
            checks++;
            if ({bus.ramREN, bus.iwait, bus.dwait} !== 3'b101 || bus.ramaddr !== 32'h200) begin
               errors++;
               $display("FAIL priority_ithen ren/iw/dw=%b addr=%h",
                        {bus.ramREN, bus.iwait, bus.dwait}, bus.ramaddr);
            end
         end
         seq_got[c] = ~bus.dwait;
         settle();
         if (c == 1) bus.dWEN = 1'b0;
      end
      clear_inputs();
   endtask

   task automatic test_starvation();
      int dcount;
      int ihit;
      apply_reset();
      dcount = 0; ihit = 0;
      bus.iREN = 1'b1; bus.iaddr = 32'h300;
      bus.dREN = 1'b1; bus.daddr = 32'h900;
      bus.ramstate = 2'd2;
      for (int c = 0; c < 16 && ihit == 0; c++) begin
         bus.ramload = $urandom;
         sample();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL starve_model cyc%0d got=%h exp=%h", c, got_v, exp_v);
         end
         if (bus.dwait === 1'b0) dcount++;
         if (bus.iwait === 1'b0) ihit = 1;
         settle();
      end
      checks++;
      if (ihit != 1 || dcount != LIMIT) begin
         errors++;
         $display("FAIL starve_count dcomp=%0d ihit=%0d exp=%0d/1", dcount, ihit, LIMIT);
      end
      // Counter cleared: with I still pending, data wins again next.
      sample();
      settle();
      sample();
      checks++;
      if (bus.dwait !== 1'b0 || bus.iwait !== 1'b1) begin
         errors++;
         $display("FAIL starve_cleared dwait=%b iwait=%b exp=0/1", bus.dwait, bus.iwait);
      end
      settle();
      clear_inputs();
   endtask

   task automatic test_ram_error();
      apply_reset();
      bus.dREN = 1'b1; bus.daddr = 32'hA0; bus.ramstate = 2'd1;
      for (int c = 0; c < 6; c++) begin
         if (c == 1) bus.ramstate = 2'd3;
         if (c == 2) begin bus.ramstate = 2'd2; bus.ramload = 32'hCAFEF00D; end
         if (c == 3) begin bus.dREN = 1'b0; bus.ramstate = 2'd0; end
         sample();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL error_model cyc%0d got=%h exp=%h", c, got_v, exp_v);
         end
         if (c == 1) begin
            checks++;
            if (bus.dwait !== 1'b1) begin
               errors++;
               $display("FAIL error_wait dwait=%b exp=1", bus.dwait);
            end
         end
         if (c == 2) begin
            checks++;
            if (bus.dwait !== 1'b0 || bus.ram_err !== 1'b1 || bus.dload !== 32'hCAFEF00D) begin
               errors++;
               $display("FAIL error_complete dwait=%b err=%b dload=%h exp=0/1/cafef00d",
                        bus.dwait, bus.ram_err, bus.dload);
            end
         end
         if (c == 5) begin
            checks++;
            if (bus.ram_err !== 1'b1) begin
               errors++;
               $display("FAIL error_sticky ram_err=%b exp=1", bus.ram_err);
            end
         end
         settle();
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_access();
      int ilow;
      apply_reset();
      ilow = 0;
      bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.ramstate = 2'd1;
      sample(); settle();          // grant
      nRST = 1'b0;                 // ISERV, RAM busy, reset sampled this edge
      sample();
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL rstmid_busy got=%h exp=%h", got_v, exp_v);
      end
      settle();
      bus.ramstate = 2'd2;
      for (int c = 0; c < 2; c++) begin
         sample();
         if (bus.iwait === 1'b0) ilow++;
         checks++;
         if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ram_err} !== 5'b00110) begin
            errors++;
            $display("FAIL rstmid_idle got=%b exp=00110",
                     {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ram_err});
         end
         settle();
      end
      checks++;
      if (ilow != 0) begin
         errors++;
         $display("FAIL rstmid_pulse iwait_low=%0d exp=0", ilow);
      end
      nRST = 1'b1;
      clear_inputs();
   endtask

   task automatic test_random();
      int r;
      int bad;
      int lows;
      apply_reset();
      bad = 0; lows = 0;
      for (int c = 0; c < 600; c++) begin
         r = $urandom_range(0, 7);
         bus.ramstate = (r == 0) ? 2'd0 : (r < 3) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
         bus.ramload  = $urandom;
         sample();
         if (got_v !== exp_v) begin
            bad++;
            if (bad <= 5) $display("FAIL random_model cyc%0d got=%h exp=%h", c, got_v, exp_v);
         end
         if (bus.iwait === 1'b0 && bus.dwait === 1'b0) lows++;
         settle();
         // Caches hold a request until their wait goes low, with rare withdrawal.
         if (!bus.iREN || !exp_v[132] || $urandom_range(0, 15) == 0) begin
            bus.iREN  = 1'($urandom_range(0, 1));
            bus.iaddr = $urandom;
         end
         if (!(bus.dREN || bus.dWEN) || !exp_v[131] || $urandom_range(0, 15) == 0) begin
            r = $urandom_range(0, 3);
            bus.dREN   = r[0];
            bus.dWEN   = r[1];
            bus.daddr  = $urandom;
            bus.dstore = $urandom;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL random_total mismatching_cycles=%0d exp=0", bad);
      end
      checks++;
      if (lows != 0) begin
         errors++;
         $display("FAIL random_one_wait both_low_cycles=%0d exp=0", lows);
      end
      clear_inputs();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      nRST   = 1'b0;
      clear_inputs();
      test_reset();
      test_ifetch_busy();
      test_priority();
      test_starvation();
      test_ram_error();
      test_reset_mid_access();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
